// File: rtl/pc_redirect_if.sv
// Signal bundle between the EX/fetch/trap logic and the PC redirect unit.
// master drives candidates and fetch handshakes, slave returns the fetch PC.
interface pc_redirect_if;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic        branch_out;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic        stall;
    logic        if_ready;
    logic        trap_ack;
    logic [31:0] trap_pc;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        flush;
    logic        misalign_exc;

    modport master (
        output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, branch_out,
        output ex_pc, ex_imm, ex_rs1, stall, if_ready, trap_ack, trap_pc,
        input  pc_out, pc_valid, flush, misalign_exc
    );

    modport slave (
        input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, branch_out,
        input  ex_pc, ex_imm, ex_rs1, stall, if_ready, trap_ack, trap_pc,
        output pc_out, pc_valid, flush, misalign_exc
    );
endinterface

// File: rtl/pc_redirect.sv
// Fetch PC generator: sequential advance, EX-stage branch/jump redirect with
// a timed pipeline flush, and misaligned-target trap handling.
module pc_redirect #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic          clk,
    input logic          rst_n,
    pc_redirect_if.slave bus
);
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        TRAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pc_q, pc_d;
    logic             pc_valid_q, pc_valid_d;
    logic             flush_q, flush_d;
    logic             misalign_q, misalign_d;

    logic        taken;
    logic        advance;
    logic [31:0] target;

    // Control-transfer resolution; jalr outranks jal, which outranks branch.
    always_comb begin
        taken   = bus.ex_is_jalr | bus.ex_is_jal | (bus.ex_is_branch & bus.branch_out);
        advance = pc_valid_q & bus.if_ready & ~bus.stall;
        if (bus.ex_is_jalr) begin
            target = (bus.ex_rs1 + bus.ex_imm) & ~32'h1;
        end else begin
            target = bus.ex_pc + bus.ex_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        flush_d    = 1'b0;
        misalign_d = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.ex_valid && taken) begin
                    if (target[1:0] == 2'b00) begin
                        pc_d       = target;
                        pc_valid_d = 1'b1;
                        flush_d    = 1'b1;
                        cnt_d      = FLUSH_LOAD;
                        state_d    = FLUSH;
                    end else begin
                        pc_valid_d = 1'b0;
                        flush_d    = 1'b1;
                        misalign_d = 1'b1;
                        state_d    = TRAP;
                    end
                end else begin
                    // Out of reset the first edge only raises pc_valid.
                    pc_valid_d = 1'b1;
                    if (advance) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            FLUSH: begin
                if (advance) begin
                    pc_d = pc_q + 32'd4;
                end
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    flush_d = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            TRAP: begin
                pc_valid_d = 1'b0;
                if (bus.trap_ack) begin
                    pc_d       = bus.trap_pc;
                    pc_valid_d = 1'b1;
                    state_d    = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign bus.pc_out       = pc_q;
    assign bus.pc_valid     = pc_valid_q;
    assign bus.flush        = flush_q;
    assign bus.misalign_exc = misalign_q;
endmodule

// File: tb/tb_pc_redirect.sv
// Directed scoreboard bench for pc_redirect: expected fetch state is queued as
// each stimulus cycle is driven and compared once the DUT has clocked it.
module tb_pc_redirect;
    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        exc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    exp_t sb_q[$];

    pc_redirect_if bus ();

    pc_redirect #(
        .RESET_PC    (32'h0000_0000),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic v, input logic f, input logic e);
        exp_t x;
        x.pc = pc; x.valid = v; x.flush = f; x.exc = e;
        sb_q.push_back(x);
    endtask

    task automatic compare(input string tag);
        exp_t x;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            x = sb_q.pop_front();
            check({tag, ".pc"},    bus.pc_out,             x.pc);
            check({tag, ".valid"}, 32'(bus.pc_valid),      32'(x.valid));
            check({tag, ".flush"}, 32'(bus.flush),         32'(x.flush));
            check({tag, ".exc"},   32'(bus.misalign_exc),  32'(x.exc));
        end
    endtask

    // Expect the given outputs after the next rising edge.
    task automatic step(input string tag, input logic [31:0] pc, input logic v,
                        input logic f, input logic e);
        push(pc, v, f, e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic ex_idle();
        bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0; bus.ex_is_jal = 1'b0;
        bus.ex_is_jalr = 1'b0; bus.branch_out = 1'b0;
    endtask

    task automatic ex_drive(input logic br, input logic jal, input logic jalr, input logic bo,
                            input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
        bus.ex_valid = 1'b1; bus.ex_is_branch = br; bus.ex_is_jal = jal;
        bus.ex_is_jalr = jalr; bus.branch_out = bo;
        bus.ex_pc = pc; bus.ex_imm = imm; bus.ex_rs1 = rs1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        ex_idle();
        bus.ex_pc = '0; bus.ex_imm = '0; bus.ex_rs1 = '0;
        bus.stall = 1'b0; bus.if_ready = 1'b1;
        bus.trap_ack = 1'b0; bus.trap_pc = '0;

        // Asynchronous reset assertion before any clock edge.
        #2 rst_n = 1'b0;
        #1 push(32'h0, 1'b0, 1'b0, 1'b0);
        compare("reset");
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        push(32'h0, 1'b0, 1'b0, 1'b0);
        compare("pre_edge");
        @(posedge clk); #1 compare_dummy();

        // Sequential fetch out of reset (first edge counted above).
        step("seq1", 32'h4, 1'b1, 1'b0, 1'b0);
        step("seq2", 32'h8, 1'b1, 1'b0, 1'b0);
        step("seq3", 32'hC, 1'b1, 1'b0, 1'b0);

        // Taken backward branch while stalled; a second candidate during flush is ignored.
        bus.stall = 1'b1;
        ex_drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'hFFFF_FFF0, 32'h0);
        step("br_taken", 32'hF0, 1'b1, 1'b1, 1'b0);
        ex_drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h10, 32'h0);
        step("flush2", 32'hF0, 1'b1, 1'b1, 1'b0);
        ex_idle();
        bus.stall = 1'b0;
        step("flush_end", 32'hF4, 1'b1, 1'b0, 1'b0);

        // Not-taken branch is a normal advance.
        ex_drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h500, 32'h40, 32'h0);
        step("br_nt", 32'hF8, 1'b1, 1'b0, 1'b0);

        // JALR clears bit 0 of the target; fetch continues during flush.
        ex_drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h3, 32'h201);
        step("jalr", 32'h204, 1'b1, 1'b1, 1'b0);
        ex_idle();
        step("jalr_fl", 32'h208, 1'b1, 1'b1, 1'b0);
        step("jalr_run", 32'h20C, 1'b1, 1'b0, 1'b0);

        // Misaligned JALR target traps until trap_ack.
        ex_drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h202);
        step("mis", 32'h20C, 1'b0, 1'b1, 1'b1);
        ex_idle();
        step("trap1", 32'h20C, 1'b0, 1'b0, 1'b0);
        step("trap2", 32'h20C, 1'b0, 1'b0, 1'b0);
        bus.trap_ack = 1'b1; bus.trap_pc = 32'h80;
        step("trap_ack", 32'h80, 1'b1, 1'b0, 1'b0);
        bus.trap_pc = 32'h500;
        step("ack_run", 32'h84, 1'b1, 1'b0, 1'b0);
        bus.trap_ack = 1'b0;

        // Wrap at the top of the address space.
        bus.stall = 1'b1;
        ex_drive(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'hC, 32'h0);
        step("jal_top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
        ex_idle();
        bus.stall = 1'b0;
        step("wrap", 32'h0, 1'b1, 1'b1, 1'b0);
        step("post_wrap", 32'h4, 1'b1, 1'b0, 1'b0);

        // Target sum wraps modulo 2^32; if_ready low holds the PC.
        ex_drive(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h20, 32'h0);
        bus.if_ready = 1'b0;
        step("sum_wrap", 32'h10, 1'b1, 1'b1, 1'b0);
        ex_idle();
        step("nr_fl", 32'h10, 1'b1, 1'b1, 1'b0);
        step("nr_run", 32'h10, 1'b1, 1'b0, 1'b0);
        bus.if_ready = 1'b1;
        step("ready", 32'h14, 1'b1, 1'b0, 1'b0);

        // jalr outranks jal when both assert.
        ex_drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h1000, 32'h100, 32'h1F00);
        step("prio", 32'h2000, 1'b1, 1'b1, 1'b0);
        ex_idle();
        step("prio_fl", 32'h2004, 1'b1, 1'b1, 1'b0);
        step("prio_run", 32'h2008, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges in the middle of a flush.
        ex_drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h3000, 32'h0, 32'h0);
        step("fl_start", 32'h3000, 1'b1, 1'b1, 1'b0);
        ex_idle();
        #2 rst_n = 1'b0;
        #1 push(32'h0, 1'b0, 1'b0, 1'b0);
        compare("rst_flush");
        @(negedge clk); rst_n = 1'b1;
        step("rel1", 32'h0, 1'b1, 1'b0, 1'b0);
        step("rel2", 32'h4, 1'b1, 1'b0, 1'b0);

        // Reset while the exception pulse is high leaves no residue.
        ex_drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h2, 32'h0);
        step("mis_br", 32'h4, 1'b0, 1'b1, 1'b1);
        ex_idle();
        #2 rst_n = 1'b0;
        #1 push(32'h0, 1'b0, 1'b0, 1'b0);
        compare("rst_trap");
        @(negedge clk); rst_n = 1'b1;
        step("rel3", 32'h0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // First edge after release: valid rises, PC stays at the reset value.
    task automatic compare_dummy();
        push(32'h0, 1'b1, 1'b0, 1'b0);
        compare("rel_edge");
    endtask
endmodule
